// File: rtl/motor_ramp_ctrl_if.sv
// Command handshake bundle for motor_ramp_ctrl.
// The command source drives valid/dir/duty; the ramp controller returns ready.
interface motor_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [9:0] cmd_duty;

    modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: slews the duty of one H-bridge motor channel toward the commanded
// target, always passing through duty 0 plus a dead time before reversing direction.
// Optional command-silence watchdog is compiled in when MOTOR_WDOG_EN is defined.
module motor_ramp_ctrl #(
    parameter logic [31:0] PWM_FREQ = 32'd20_000,
    parameter int unsigned RAMP_DIV = 100_000,
    parameter logic [9:0]  STEP     = 10'd32,
    parameter int unsigned DEAD_CYC = 50_000,
    parameter int unsigned WDOG_CYC = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    motor_ramp_ctrl_if.slave   cmd,
    input  logic               estop,
    output logic [31:0]        pwm_freq,
    output logic [9:0]         pwm_duty,
    output logic               dir_out,
    output logic               busy,
    output logic               at_target,
    output logic               wdog_trip
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    localparam logic [31:0] RAMP_LAST = 32'(RAMP_DIV - 1);
    localparam logic [31:0] DEAD_LAST = 32'(DEAD_CYC - 1);

    logic [1:0]  state;
    logic [31:0] prescaler;
    logic [31:0] dead_cnt;
    logic [9:0]  tgt_duty;
    logic        tgt_dir;
    logic        tick;
    logic        accept;
    logic        wdog_fire;
    logic        dir_mismatch;
    logic [10:0] cur11;
    logic [10:0] tgt11;
    logic [10:0] stp11;
    logic [9:0]  ramp_down;
    logic [9:0]  ramp_to;

    assign pwm_freq      = PWM_FREQ;
    assign cmd.cmd_ready = (state != S_DEAD) && !estop;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign tick          = (prescaler == RAMP_LAST);
    assign dir_mismatch  = (tgt_dir != dir_out);
    assign busy          = (state == S_RAMP) || (state == S_DEAD);
    assign at_target     = (state == S_IDLE) || (state == S_HOLD);

    // Free-running ramp prescaler; commands never realign it.
    always_ff @(posedge clk) begin
        if (reset || tick) prescaler <= '0;
        else               prescaler <= prescaler + 32'd1;
    end

    // Next duty one step toward 0 or toward the target, clamped in 11 bits so no overshoot or wrap.
    always_comb begin
        cur11 = {1'b0, pwm_duty};
        tgt11 = {1'b0, tgt_duty};
        stp11 = {1'b0, STEP};
        ramp_down = (cur11 <= stp11) ? '0 : 10'(cur11 - stp11);
        if (cur11 < tgt11)
            ramp_to = ((tgt11 - cur11) <= stp11) ? tgt_duty : 10'(cur11 + stp11);
        else
            ramp_to = ((cur11 - tgt11) <= stp11) ? tgt_duty : 10'(cur11 - stp11);
    end

    // Target registers and ramp/dead-time state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_duty <= '0;
            dir_out  <= 1'b1;
            tgt_duty <= '0;
            tgt_dir  <= 1'b1;
            state    <= S_IDLE;
            dead_cnt <= '0;
        end else if (estop) begin
            pwm_duty <= '0;
            tgt_duty <= '0;
            state    <= S_IDLE;
            dead_cnt <= '0;
        end else begin
            if (accept) begin
                tgt_duty <= cmd.cmd_duty;
                tgt_dir  <= cmd.cmd_dir;
            end else if (wdog_fire) begin
                tgt_duty <= '0;
            end
            case (state)
                S_IDLE, S_HOLD: begin
                    if ((tgt_duty != pwm_duty) || dir_mismatch) state <= S_RAMP;
                end
                S_RAMP: begin
                    if (dir_mismatch) begin
                        if (pwm_duty == '0) begin
                            state    <= S_DEAD;
                            dead_cnt <= '0;
                        end else if (tick) begin
                            pwm_duty <= ramp_down;
                            if (ramp_down == '0) begin
                                state    <= S_DEAD;
                                dead_cnt <= '0;
                            end
                        end
                    end else if (pwm_duty == tgt_duty) begin
                        state <= (tgt_duty == '0) ? S_IDLE : S_HOLD;
                    end else if (tick) begin
                        pwm_duty <= ramp_to;
                        if (ramp_to == tgt_duty) state <= (tgt_duty == '0) ? S_IDLE : S_HOLD;
                    end
                end
                S_DEAD: begin
                    pwm_duty <= '0;
                    if (dead_cnt == DEAD_LAST) begin
                        dead_cnt <= '0;
                        dir_out  <= tgt_dir;
                        state    <= (tgt_duty == '0) ? S_IDLE : S_RAMP;
                    end else begin
                        dead_cnt <= dead_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MOTOR_WDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYC - 1);
    localparam logic [31:0] WDOG_LIM  = 32'(WDOG_CYC);

    logic [31:0] wdog_cnt;
    logic        wdog_flag;

    // Fires once, on the cycle the silence counter reaches the limit.
    assign wdog_fire = !estop && !accept && (wdog_cnt == WDOG_LAST);
    assign wdog_trip = wdog_flag;

    // Saturating command-silence counter and sticky trip flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else if (estop) begin
            wdog_cnt  <= '0;
        end else if (accept) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else begin
            if (wdog_cnt != WDOG_LIM) wdog_cnt <= wdog_cnt + 32'd1;
            if (wdog_fire)            wdog_flag <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with RAMP_DIV=4, STEP=64, DEAD_CYC=8, WDOG_CYC=200.
module tb_motor_ramp_ctrl;

    logic        clk;
    logic        reset;
    logic        estop;
    logic [31:0] pwm_freq;
    logic [9:0]  pwm_duty;
    logic        dir_out;
    logic        busy;
    logic        at_target;
    logic        wdog_trip;

    int vectors;
    int miscompares;
    int gap;

    motor_ramp_ctrl_if cmd_if();

    motor_ramp_ctrl #(
        .PWM_FREQ (32'd20_000),
        .RAMP_DIV (4),
        .STEP     (10'd64),
        .DEAD_CYC (8),
        .WDOG_CYC (200)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd_if),
        .estop     (estop),
        .pwm_freq  (pwm_freq),
        .pwm_duty  (pwm_duty),
        .dir_out   (dir_out),
        .busy      (busy),
        .at_target (at_target),
        .wdog_trip (wdog_trip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one command at a negedge; it is accepted on the following posedge.
    task automatic send_cmd(input logic d, input logic [9:0] v);
        check("cmd_ready_before_cmd", {31'd0, cmd_if.cmd_ready}, 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_duty  = v;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for pwm_duty to change, then compare the new value.
    task automatic wait_duty(input string tag, input logic [9:0] exp, output int n);
        logic [9:0] start;
        start = pwm_duty;
        n = 0;
        while (pwm_duty == start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {22'd0, pwm_duty}, {22'd0, exp});
    endtask

    // Wait (bounded) for dir_out to change, then compare it.
    task automatic wait_dir(input string tag, input logic exp, output int n);
        logic start;
        start = dir_out;
        n = 0;
        while (dir_out == start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, dir_out}, {31'd0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        estop            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_duty  = '0;

        // 1: reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_duty",     {22'd0, pwm_duty}, 32'd0);
        check("rst_dir",      {31'd0, dir_out}, 32'd1);
        check("rst_at_target",{31'd0, at_target}, 32'd1);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_ready",    {31'd0, cmd_if.cmd_ready}, 32'd1);
        check("rst_wdog",     {31'd0, wdog_trip}, 32'd0);
        check("pwm_freq",     pwm_freq, 32'd20000);

        // 2: forward 256 from rest
        send_cmd(1'b1, 10'd256);
        wait_duty("s2_64", 10'd64, gap);
        wait_duty("s2_128", 10'd128, gap);
        check("s2_gap128", gap, 32'd4);
        wait_duty("s2_192", 10'd192, gap);
        check("s2_gap192", gap, 32'd4);
        wait_duty("s2_256", 10'd256, gap);
        check("s2_gap256", gap, 32'd4);
        check("s2_at_target", {31'd0, at_target}, 32'd1);
        check("s2_busy", {31'd0, busy}, 32'd0);

        // 3: retarget down to 100 (clamped last step), then to 0
        send_cmd(1'b1, 10'd100);
        wait_duty("s3_192", 10'd192, gap);
        wait_duty("s3_128", 10'd128, gap);
        wait_duty("s3_100", 10'd100, gap);
        check("s3_hold", {31'd0, at_target}, 32'd1);
        send_cmd(1'b1, 10'd0);
        wait_duty("s3_36", 10'd36, gap);
        wait_duty("s3_0", 10'd0, gap);
        check("s3_gap0", gap, 32'd4);
        check("s3_idle", {31'd0, at_target}, 32'd1);
        check("s3_dir", {31'd0, dir_out}, 32'd1);

        // 4: forward 256 then reverse 128 through dead time
        send_cmd(1'b1, 10'd256);
        wait_duty("s4_up64", 10'd64, gap);
        wait_duty("s4_up128", 10'd128, gap);
        wait_duty("s4_up192", 10'd192, gap);
        wait_duty("s4_up256", 10'd256, gap);
        send_cmd(1'b0, 10'd128);
        wait_duty("s4_dn192", 10'd192, gap);
        wait_duty("s4_dn128", 10'd128, gap);
        wait_duty("s4_dn64", 10'd64, gap);
        wait_duty("s4_dn0", 10'd0, gap);
        check("s4_dead_busy", {31'd0, busy}, 32'd1);
        check("s4_dead_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        check("s4_dead_dir", {31'd0, dir_out}, 32'd1);
        wait_dir("s4_flip", 1'b0, gap);
        check("s4_dead_len", gap, 32'd8);
        check("s4_flip_duty", {22'd0, pwm_duty}, 32'd0);
        wait_duty("s4_rev64", 10'd64, gap);
        wait_duty("s4_rev128", 10'd128, gap);
        check("s4_hold", {31'd0, at_target}, 32'd1);

        // 5: estop at duty 192
        send_cmd(1'b0, 10'd256);
        wait_duty("s5_192", 10'd192, gap);
        estop = 1'b1;
        @(negedge clk);
        check("s5_duty", {22'd0, pwm_duty}, 32'd0);
        check("s5_idle", {31'd0, at_target}, 32'd1);
        check("s5_ready", {31'd0, cmd_if.cmd_ready}, 32'd0);
        check("s5_dir_kept", {31'd0, dir_out}, 32'd0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_duty  = 10'd512;
        repeat (6) @(negedge clk);
        check("s5_ignored_duty", {22'd0, pwm_duty}, 32'd0);
        check("s5_ignored_busy", {31'd0, busy}, 32'd0);
        cmd_if.cmd_valid = 1'b0;
        estop = 1'b0;
        repeat (3) @(negedge clk);
        check("s5_after_busy", {31'd0, busy}, 32'd0);
        check("s5_after_duty", {22'd0, pwm_duty}, 32'd0);

        // 6: reverse -> forward from idle via dead time, then watchdog behaviour
        send_cmd(1'b1, 10'd128);
        wait_dir("s6_flip", 1'b1, gap);
        wait_duty("s6_64", 10'd64, gap);
        wait_duty("s6_128", 10'd128, gap);
`ifdef MOTOR_WDOG_EN
        gap = 0;
        while (!wdog_trip && gap < 300) begin
            @(negedge clk);
            gap++;
        end
        check("s6_trip", {31'd0, wdog_trip}, 32'd1);
        wait_duty("s6_wd64", 10'd64, gap);
        wait_duty("s6_wd0", 10'd0, gap);
        check("s6_wd_idle", {31'd0, at_target}, 32'd1);
        send_cmd(1'b1, 10'd64);
        check("s6_trip_clr", {31'd0, wdog_trip}, 32'd0);
`else
        repeat (250) @(negedge clk);
        check("s6_persist_duty", {22'd0, pwm_duty}, 32'd128);
        check("s6_no_trip", {31'd0, wdog_trip}, 32'd0);
        check("s6_persist_hold", {31'd0, at_target}, 32'd1);
`endif

        // reset in the middle of a reversal aborts it
        send_cmd(1'b0, 10'd256);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_duty", {22'd0, pwm_duty}, 32'd0);
        check("mid_rst_dir", {31'd0, dir_out}, 32'd1);
        check("mid_rst_idle", {31'd0, at_target}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
